line_assembly_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets NUM_REQ cores share one 128-bit line-assembly datapath in the multicore MIPS32 system. A granted core streams exactly WORDS_PER_LINE 32-bit words, which are shifted into a line register. The completed line is then presented downstream with a valid/ready handshake, tagged with the owning core's index. The block sits between the per-core store/writeback ports and the shared memory-side line interface.

---
 rtl/lac_pkg.sv | 14 +
 rtl/word_shift_reg.sv | 33 +++
 rtl/line_assembly_arbiter.sv | 128 ++++++++++++
 tb/tb_line_assembly_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lac_pkg.sv
// Shared types and default geometry for the line assembly arbiter.
package lac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int LAC_WORD_W         = 32;
    localparam int LAC_WORDS_PER_LINE = 4;
    localparam int LAC_LINE_W         = LAC_WORD_W * LAC_WORDS_PER_LINE;

endpackage

// File: rtl/word_shift_reg.sv
// Line register: each accepted word enters the top slot while older words move down.
module word_shift_reg #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] word_in,
    output logic [LINE_W-1:0] line_out
);

    logic [LINE_W-1:0] line_d;
    logic [LINE_W-1:0] line_q;

    always_comb begin
        line_d = line_q;
        if (shift_en) begin
            line_d = {word_in, line_q[LINE_W-1:WORD_W]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_out = line_q;

endmodule

// File: rtl/line_assembly_arbiter.sv
// Round-robin arbiter that lets one core at a time stream a full line of words,
// then offers the assembled line downstream tagged with the owner index.
//
// Handshakes: a word transfers on a cycle where req_valid[i] & req_ready[i];
// a line transfers on a cycle where line_valid & line_ready. Valid, once high,
// holds its payload stable until the transfer; ready is driven from state only.
module line_assembly_arbiter
    import lac_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WORD_W         = LAC_WORD_W,
    parameter int WORDS_PER_LINE = LAC_WORDS_PER_LINE,
    parameter int LINE_W         = WORD_W * WORDS_PER_LINE,
    parameter int OWN_W          = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      line_valid,
    output logic [LINE_W-1:0]         line_data,
    output logic [OWN_W-1:0]          line_owner,
    input  logic                      line_ready,
    output logic                      busy,
    output state_e                    dbg_state
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

    state_e             state_q,  state_d;
    logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]   owner_q,  owner_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               grant_valid;
    logic [OWN_W-1:0]   grant_idx;
    logic [OWN_W-1:0]   scan_idx;
    logic               accept;
    logic [WORD_W-1:0]  owner_word;

    // Scan from rr_ptr upward; the index wraps because NUM_REQ is a power of 2.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = rr_ptr_q + OWN_W'(i);
            if (!grant_valid && req_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign accept     = (state_q == COLLECT) && req_valid[owner_q];
    assign owner_word = req_data[owner_q*WORD_W +: WORD_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d  = grant_idx;
                    rr_ptr_d = grant_idx + OWN_W'(1);
                    count_d  = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (line_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
        end
    end

    word_shift_reg #(
        .WORD_W (WORD_W),
        .LINE_W (LINE_W)
    ) u_line (
        .Clk      (Clk),
        .Reset    (Reset),
        .shift_en (accept),
        .word_in  (owner_word),
        .line_out (line_data)
    );

    always_comb begin
        req_ready = '0;
        if (state_q == COLLECT) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    assign line_valid = (state_q == HOLD);
    assign line_owner = owner_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_assembly_arbiter.sv
// Directed bench for line_assembly_arbiter: per-core word streams feed the DUT,
// each scenario task checks grant order, latency and assembled line contents.
module tb_line_assembly_arbiter;
    import lac_pkg::*;

    logic          Clk;
    logic          Reset;
    logic [3:0]    req_valid;
    logic [127:0]  req_data;
    logic [3:0]    req_ready;
    logic          line_valid;
    logic [127:0]  line_data;
    logic [1:0]    line_owner;
    logic          line_ready;
    logic          busy;
    state_e        dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-core stream model: word k of core c is first[c] + k*stepv[c].
    logic [31:0] first [4];
    logic [31:0] stepv [4];
    int unsigned base [4];
    int unsigned len [4];
    bit          pause [4];
    int unsigned acc_cnt [4] = '{default: 0};

    line_assembly_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .line_valid (line_valid),
        .line_data  (line_data),
        .line_owner (line_owner),
        .line_ready (line_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!Reset && req_valid[i] && req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
        end
    end

    always_comb begin
        int unsigned idx;
        req_valid = '0;
        req_data  = '0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            idx = acc_cnt[i] - base[i];
            req_valid[i] = (idx < len[i]) && !pause[i];
            req_data[i*32 +: 32] = first[i] + idx * stepv[i];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic load_core(input int c, input int n, input logic [31:0] f, input logic [31:0] s);
        base[c]  = acc_cnt[c];
        len[c]   = n;
        first[c] = f;
        stepv[c] = s;
        pause[c] = 1'b0;
    endtask

    function automatic logic [127:0] exp_line(input logic [31:0] f, input logic [31:0] s, input int k0);
        logic [31:0] k;
        k = k0;
        return {f + (k + 3) * s, f + (k + 2) * s, f + (k + 1) * s, f + k * s};
    endfunction

    task automatic wait_valid(input int budget, input string nm);
        int n;
        n = 0;
        while (!line_valid && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (!line_valid) begin
            errors++;
            $display("FAIL %s: line_valid not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(2);
        checks++;
        if (req_ready !== 4'b0 || line_valid !== 1'b0 || line_data !== 128'b0 ||
            line_owner !== 2'd0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b lv=%b ld=%h own=%0d busy=%b st=%0d, required all zero/IDLE",
                     req_ready, line_valid, line_data, line_owner, busy, dbg_state);
        end
        Reset = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b required 0", busy);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_own [5];
        int k0 [5];
        int line_no;
        int prev;
        int n;
        exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        k0      = '{0, 0, 0, 0, 4};
        line_no = 0;
        prev    = 0;
        n       = 0;
        line_ready = 1'b1;
        load_core(0, 8, 32'hC000_0000, 32'h1);
        load_core(1, 4, 32'hC001_0000, 32'h1);
        load_core(2, 4, 32'hC002_0000, 32'h1);
        load_core(3, 4, 32'hC003_0000, 32'h1);
        while (line_no < 5 && n < 60) begin
            step(1);
            n++;
            checks++;
            if ((req_ready & ~(4'b1 << exp_own[line_no])) !== 4'b0) begin
                errors++;
                $display("FAIL fair_nonowner_ready: rdy=%b required only bit %0d", req_ready, exp_own[line_no]);
            end
            if (line_valid) begin
                checks++;
                if (line_owner !== exp_own[line_no] ||
                    line_data !== exp_line(first[exp_own[line_no]], 32'h1, k0[line_no])) begin
                    errors++;
                    $display("FAIL fair_line%0d: owner=%0d data=%h required owner=%0d data=%h", line_no,
                             line_owner, line_data, exp_own[line_no],
                             exp_line(first[exp_own[line_no]], 32'h1, k0[line_no]));
                end
                if (line_no == 0) begin
                    checks++;
                    if (n != 5) begin
                        errors++;
                        $display("FAIL fair_first_latency: %0d cycles required 5", n);
                    end
                end else begin
                    checks++;
                    if (cyc - prev != 6) begin
                        errors++;
                        $display("FAIL fair_spacing%0d: %0d cycles required 6", line_no, cyc - prev);
                    end
                end
                prev = cyc;
                line_no++;
            end
        end
        checks++;
        if (line_no != 5) begin
            errors++;
            $display("FAIL fair_count: %0d lines required 5", line_no);
        end
        step(1);
    endtask

    task automatic test_single_core();
        logic exp_busy;
        logic exp_valid;
        logic [3:0] exp_rdy;
        line_ready = 1'b1;
        load_core(2, 4, 32'h1111_1111, 32'h1111_1111);
        for (int s = 1; s <= 6; s++) begin
            step(1);
            exp_busy  = (s <= 5);
            exp_valid = (s == 5);
            exp_rdy   = (s <= 4) ? 4'b0100 : 4'b0000;
            checks++;
            if (busy !== exp_busy || line_valid !== exp_valid || req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL single_cycle%0d: busy=%b lv=%b rdy=%b required busy=%b lv=%b rdy=%b",
                         s, busy, line_valid, req_ready, exp_busy, exp_valid, exp_rdy);
            end
            if (s == 5) begin
                checks++;
                if (line_data !== 128'h44444444_33333333_22222222_11111111 || line_owner !== 2'd2) begin
                    errors++;
                    $display("FAIL single_line: data=%h owner=%0d required 44444444333333332222222211111111 owner=2",
                             line_data, line_owner);
                end
            end
        end
    endtask

    task automatic test_stall();
        line_ready = 1'b1;
        load_core(3, 4, 32'h5000_0003, 32'h0101_0000);
        step(3);
        checks++;
        if (acc_cnt[3] - base[3] != 2) begin
            errors++;
            $display("FAIL stall_pre_gap: %0d words accepted required 2", acc_cnt[3] - base[3]);
        end
        pause[3] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step(1);
            checks++;
            if (req_ready !== 4'b1000 || line_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_gap%0d: rdy=%b lv=%b required rdy=1000 lv=0", g, req_ready, line_valid);
            end
        end
        pause[3] = 1'b0;
        step(1);
        checks++;
        if (line_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: line_valid=%b required 0 with one word left", line_valid);
        end
        step(1);
        checks++;
        if (line_valid !== 1'b1 || line_owner !== 2'd3 ||
            line_data !== 128'h53030003_52020003_51010003_50000003) begin
            errors++;
            $display("FAIL stall_line: lv=%b owner=%0d data=%h required lv=1 owner=3 data=53030003520200035101000350000003",
                     line_valid, line_owner, line_data);
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        line_ready = 1'b0;
        load_core(0, 4, 32'hB000_0000, 32'h10);
        load_core(1, 4, 32'hB100_0000, 32'h10);
        wait_valid(20, "bp_wait0");
        for (int h = 0; h < 10; h++) begin
            checks++;
            if (line_valid !== 1'b1 || line_owner !== 2'd0 || req_ready !== 4'b0 ||
                line_data !== 128'hB0000030_B0000020_B0000010_B0000000) begin
                errors++;
                $display("FAIL bp_hold%0d: lv=%b owner=%0d rdy=%b data=%h required lv=1 owner=0 rdy=0000 data=B0000030B0000020B0000010B0000000",
                         h, line_valid, line_owner, req_ready, line_data);
            end
            step(1);
        end
        line_ready = 1'b1;
        step(1);
        checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: lv=%b busy=%b required 0 0", line_valid, busy);
        end
        step(1);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next_grant: rdy=%b required 0010", req_ready);
        end
        wait_valid(20, "bp_wait1");
        checks++;
        if (line_owner !== 2'd1 || line_data !== 128'hB1000030_B1000020_B1000010_B1000000) begin
            errors++;
            $display("FAIL bp_line1: owner=%0d data=%h required owner=1 data=B1000030B1000020B1000010B1000000",
                     line_owner, line_data);
        end
        step(1);
    endtask

    task automatic test_reset_mid();
        line_ready = 1'b1;
        load_core(0, 4, 32'hD000_0000, 32'h1);
        step(3);
        checks++;
        if (acc_cnt[0] - base[0] != 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: %0d words busy=%b required 2 words busy=1", acc_cnt[0] - base[0], busy);
        end
        Reset = 1'b1;
        load_core(0, 0, 32'h0, 32'h0);
        step(1);
        Reset = 1'b0;
        checks++;
        if (req_ready !== 4'b0 || line_valid !== 1'b0 || line_data !== 128'b0 ||
            line_owner !== 2'd0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rmid_outputs: rdy=%b lv=%b ld=%h own=%0d busy=%b st=%0d, required all zero/IDLE",
                     req_ready, line_valid, line_data, line_owner, busy, dbg_state);
        end
        load_core(0, 4, 32'hE000_0000, 32'h1);
        load_core(2, 4, 32'hE200_0000, 32'h1);
        step(1);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_grant: rdy=%b required 0001", req_ready);
        end
        wait_valid(20, "rmid_wait0");
        checks++;
        if (line_owner !== 2'd0 || line_data !== 128'hE0000003_E0000002_E0000001_E0000000) begin
            errors++;
            $display("FAIL rmid_line0: owner=%0d data=%h required owner=0 data=E0000003E0000002E0000001E0000000",
                     line_owner, line_data);
        end
        step(1);
        wait_valid(20, "rmid_wait2");
        checks++;
        if (line_owner !== 2'd2 || line_data !== 128'hE2000003_E2000002_E2000001_E2000000) begin
            errors++;
            $display("FAIL rmid_line2: owner=%0d data=%h required owner=2 data=E2000003E2000002E2000001E2000000",
                     line_owner, line_data);
        end
        step(1);
    endtask

    initial begin
        Reset      = 1'b1;
        line_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            base[i]  = 0;
            len[i]   = 0;
            first[i] = '0;
            stepv[i] = '0;
            pause[i] = 1'b0;
        end
        test_reset();
        test_fairness();
        test_single_core();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
